vga_stream_decoder: RTL and testbench
=====================================

# vga_stream_decoder

Receive-side counterpart of the VGA frame-buffer display: monitors the VGA output bus (HS, VS, BLANK_N, 8-bit RGB) on the pixel clock, reconstructs active-pixel coordinates, maps each pixel back to the 2-bit map colour code (0 black, 1 red, 2 green, 3 blue), and packs each active line into one 1696-bit line word. It sits beside the display path as a loop-back checker for bench regression and on-board self-test, reporting line data, frame geometry and sticky timing/colour errors.

## Interface
- H_ACTIVE, 848, active pixels per line
- V_ACTIVE, 480, active lines per frame
- pixelCLK  in  1  pixel clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- VGA_HS  in  1  horizontal sync, active-low
- VGA_VS  in  1  vertical sync, active-low
- VGA_BLANK_N  in  1  high = active pixel
- VGA_R, VGA_G, VGA_B  in  8 each  pixel colour
- lineData  out  2*H_ACTIVE  packed codes, pixel n at [2n+1:2n]
- lineValid  out  1  one-cycle pulse, lineData/lineIdx valid
- lineIdx  out  9  active line number of lineData, 0-based
- frameDone  out  1  one-cycle pulse at end of frame
- activeHeight  out  9  lines captured in last completed frame
- timingErr  out  1  sticky geometry/sync error
- colorErr  out  1  sticky illegal-colour error
- frameCrc  out  16  CRC of last completed frame (see Configuration)

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- Inputs registered once (1-stage sync); edges detected on registered values.
- States: IDLE -> FRAME on VS falling edge. FRAME -> LINE on BLANK_N rising edge. LINE -> FRAME on BLANK_N falling edge (emit line). FRAME/LINE -> FRAME on VS falling edge (frame end, new frame).
- LINE: each active pixel shifts its code into shift register from the top (right-shift by 2, insert at [2*H_ACTIVE-1:2*H_ACTIVE-2]); column counter increments. After exactly H_ACTIVE pixels pixel 0 lands at [1:0].
- Colour decode: (255,0,0)=1, (0,255,0)=2, (0,0,255)=3, (0,0,0)=0; any other value -> code 0, colorErr set.
- Line emit: lineData <= shift register, lineIdx <= line counter, lineValid pulse; line counter +1.
- Column count != H_ACTIVE at line end: line still emitted, timingErr set. Pixels beyond H_ACTIVE are not shifted in.
- Line counter reaching V_ACTIVE: further lines ignored (no lineValid), timingErr set.
- VS falling edge in LINE: partial line discarded, no lineValid, timingErr set.
- VS falling edge with line counter > 0: frameDone pulse, activeHeight <= line counter; line counter reset. Line counter != V_ACTIVE also sets timingErr. Line counter 0 (first VS after reset): no frameDone.
- Error flags cleared only by RST.

## Timing
- Input register: 1 cycle. lineValid asserts 2 cycles after the first BLANK_N-low pixel on the bus.
- frameDone asserts 2 cycles after VS falls on the bus; same cycle as activeHeight/frameCrc update.
- lineData held stable until the next lineValid.
- RST mid-line: immediate return to IDLE, partial data discarded, no pulses.
- Simultaneous VS fall and BLANK_N fall: VS takes priority (line discarded).

## Configuration
- VGA_DEC_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) over every emitted pixel code, 2 bits per pixel MSB first, in line order; result latched to frameCrc at frameDone, engine reinitialised.
- Undefined: no CRC logic; frameCrc tied to 0.

## Structure
- Package vga_dec_pkg: state enum (IDLE, FRAME, LINE), colour code constants, default H_ACTIVE/V_ACTIVE.
- One sub-module: crc16_2b (2-bit-per-cycle CRC update), instantiated only under VGA_DEC_CRC_EN.

## Test plan
- Reset then frame of 480 lines x 848 pixels, pixel n code = n%4 -> 480 lineValid, lineData[1:0]=0, [3:2]=1, [1695:1694]=3; frameDone with activeHeight=480; no errors.
- Line of 847 pixels -> lineValid still pulses, timingErr=1.
- Pixel (128,0,0) -> decoded code 0, colorErr=1, sticky across next frame.
- VS falls at column 400 of line 10 -> no lineValid for line 10, timingErr=1, frameDone with activeHeight=10.
- RST pulse mid-line 5 -> outputs all 0, next lineValid only after a fresh VS fall, lineIdx=0.
- With VGA_DEC_CRC_EN, all-black 848x480 frame -> frameCrc equals model CRC of 407040 zero codes; without macro frameCrc=0.

Source files
------------

// File: rtl/vga_dec_pkg.sv
// Shared types and constants for the VGA stream decoder: FSM states, colour codes,
// default geometry and CRC-16-CCITT parameters.
package vga_dec_pkg;

   localparam int H_ACTIVE_DEF = 848;
   localparam int V_ACTIVE_DEF = 480;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      LINE  = 2'd2
   } decState_t;

   localparam logic [1:0] CODE_BLACK = 2'd0;
   localparam logic [1:0] CODE_RED   = 2'd1;
   localparam logic [1:0] CODE_GREEN = 2'd2;
   localparam logic [1:0] CODE_BLUE  = 2'd3;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h1021;

endpackage

// File: rtl/vga_stream_decoder_if.sv
// VGA output bus as seen by the decoder; master drives the bus (display side or bench),
// slave observes it.
interface vga_stream_decoder_if;

   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;

   modport master (output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B);
   modport slave  (input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B);

endinterface

// File: rtl/crc16_2b.sv
// CRC-16-CCITT update for one 2-bit pixel code per cycle, code MSB first, no reflection.
module crc16_2b
   import vga_dec_pkg::*;
(
   input  logic [15:0] crcIn,
   input  logic [1:0]  code,
   output logic [15:0] crcOut
);

   logic        fbHi;
   logic        fbLo;
   logic [15:0] crcMid;

   always_comb begin
      fbHi   = crcIn[15] ^ code[1];
      crcMid = {crcIn[14:0], 1'b0} ^ (fbHi ? CRC_POLY : 16'h0000);
      fbLo   = crcMid[15] ^ code[0];
      crcOut = {crcMid[14:0], 1'b0} ^ (fbLo ? CRC_POLY : 16'h0000);
   end

endmodule

// File: rtl/vga_stream_decoder.sv
// Loop-back checker for the VGA display bus: rebuilds active lines as packed 2-bit colour
// codes and flags geometry/colour errors. Define VGA_DEC_CRC_EN to add a per-frame CRC-16.
module vga_stream_decoder
   import vga_dec_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic                    pixelCLK,
   input  logic                    RST,
   vga_stream_decoder_if.slave     vga,
   output logic [2*H_ACTIVE-1:0]   lineData,
   output logic                    lineValid,
   output logic [8:0]              lineIdx,
   output logic                    frameDone,
   output logic [8:0]              activeHeight,
   output logic                    timingErr,
   output logic                    colorErr,
   output logic [15:0]             frameCrc
);

   localparam int               COL_W  = $clog2(H_ACTIVE + 2);
   localparam logic [COL_W-1:0] H_LAST = COL_W'(H_ACTIVE);
   localparam logic [8:0]       V_LAST = 9'(V_ACTIVE);

   // Returns {illegal, code}; anything but the four pure colours decodes as black.
   function automatic logic [2:0] decodeColor(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
      if (r == 8'hFF && g == 8'h00 && b == 8'h00)      return {1'b0, CODE_RED};
      else if (r == 8'h00 && g == 8'hFF && b == 8'h00) return {1'b0, CODE_GREEN};
      else if (r == 8'h00 && g == 8'h00 && b == 8'hFF) return {1'b0, CODE_BLUE};
      else if (r == 8'h00 && g == 8'h00 && b == 8'h00) return {1'b0, CODE_BLACK};
      else                                             return {1'b1, CODE_BLACK};
   endfunction

   logic vs_p0, vs_p1, blankN_p0, blankN_p1;
   logic [7:0] red_p0, green_p0, blue_p0;

   decState_t state, stateNext;
   logic [COL_W-1:0] colCnt;
   logic [8:0] lineCnt;
   logic [2*H_ACTIVE-1:0] shiftReg;

   logic vsFall, blankRise, blankFall;
   logic lineStart, inLinePix, shiftEn, emit, emitOk, pixBad;
   logic [1:0] pixCode;

   // stage p0/p1: input register, then one more tap for edge detection
   always_ff @(posedge pixelCLK or posedge RST) begin
      if (RST) begin
         vs_p0     <= 1'b1;
         vs_p1     <= 1'b1;
         blankN_p0 <= 1'b0;
         blankN_p1 <= 1'b0;
      end else begin
         vs_p0     <= vga.VGA_VS;
         vs_p1     <= vs_p0;
         blankN_p0 <= vga.VGA_BLANK_N;
         blankN_p1 <= blankN_p0;
      end
   end

   always_ff @(posedge pixelCLK) begin
      red_p0   <= vga.VGA_R;
      green_p0 <= vga.VGA_G;
      blue_p0  <= vga.VGA_B;
   end

   assign vsFall    = vs_p1 & ~vs_p0;
   assign blankRise = blankN_p0 & ~blankN_p1;
   assign blankFall = ~blankN_p0 & blankN_p1;
   assign {pixBad, pixCode} = decodeColor(red_p0, green_p0, blue_p0);

   always_comb begin
      stateNext = state;
      lineStart = 1'b0;
      inLinePix = 1'b0;
      emit      = 1'b0;
      case (state)
         IDLE:  if (vsFall) stateNext = FRAME;
         FRAME: begin
            if (vsFall) stateNext = FRAME;
            else if (blankRise) begin
               stateNext = LINE;
               lineStart = 1'b1;
            end
         end
         LINE: begin
            if (vsFall) stateNext = FRAME;
            else if (blankFall) begin
               stateNext = FRAME;
               emit      = 1'b1;
            end else if (blankN_p0) inLinePix = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   // The first pixel of a line is consumed on the same cycle the rising blank edge is seen.
   assign shiftEn = lineStart | (inLinePix & (colCnt < H_LAST));
   assign emitOk  = emit & (lineCnt != V_LAST);

   always_ff @(posedge pixelCLK) begin
      if (shiftEn) shiftReg <= {pixCode, shiftReg[2*H_ACTIVE-1:2]};
   end

   // stage p2: control state and registered outputs
   always_ff @(posedge pixelCLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         colCnt       <= '0;
         lineCnt      <= '0;
         lineData     <= '0;
         lineValid    <= 1'b0;
         lineIdx      <= '0;
         frameDone    <= 1'b0;
         activeHeight <= '0;
         timingErr    <= 1'b0;
         colorErr     <= 1'b0;
      end else begin
         state     <= stateNext;
         lineValid <= 1'b0;
         frameDone <= 1'b0;

         // Counter saturates one past H_ACTIVE so long lines stay distinguishable.
         if (lineStart) colCnt <= COL_W'(1);
         else if (inLinePix && colCnt <= H_LAST) colCnt <= colCnt + 1'b1;

         if ((lineStart || inLinePix) && pixBad) colorErr <= 1'b1;

         if (vsFall) begin
            if (state == LINE) timingErr <= 1'b1;
            if (lineCnt != 9'd0) begin
               frameDone    <= 1'b1;
               activeHeight <= lineCnt;
               if (lineCnt != V_LAST) timingErr <= 1'b1;
            end
            lineCnt <= '0;
         end else if (emit) begin
            if (colCnt != H_LAST) timingErr <= 1'b1;
            if (emitOk) begin
               lineValid <= 1'b1;
               lineData  <= shiftReg;
               lineIdx   <= lineCnt;
               lineCnt   <= lineCnt + 9'd1;
            end else begin
               timingErr <= 1'b1;
            end
         end
      end
   end

`ifdef VGA_DEC_CRC_EN
   logic [15:0] crcFrame, crcLine, crcSeed, crcNext;

   // Lines run on a speculative copy that only commits when the line is emitted.
   assign crcSeed = lineStart ? crcFrame : crcLine;

   crc16_2b u_crc16 (
      .crcIn  (crcSeed),
      .code   (pixCode),
      .crcOut (crcNext)
   );

   always_ff @(posedge pixelCLK or posedge RST) begin
      if (RST) begin
         crcFrame <= CRC_INIT;
         crcLine  <= CRC_INIT;
         frameCrc <= '0;
      end else begin
         if (shiftEn) crcLine <= crcNext;
         if (emitOk) crcFrame <= crcLine;
         if (vsFall) begin
            if (lineCnt != 9'd0) frameCrc <= crcFrame;
            crcFrame <= CRC_INIT;
         end
      end
   end
`else
   assign frameCrc = '0;
`endif

endmodule

// File: tb/tb_vga_stream_decoder.sv
// Directed bench for vga_stream_decoder using a reduced frame height (12 lines) at full
// 848-pixel width so the whole run stays short; CRC expectation follows VGA_DEC_CRC_EN.
`timescale 1ns/1ps
module tb_vga_stream_decoder;
   import vga_dec_pkg::*;

   localparam int H      = 848;
   localparam int V      = 12;
   localparam int HBLANK = 8;

   logic pixelCLK = 1'b0;
   logic RST;
   always #5 pixelCLK = ~pixelCLK;

   vga_stream_decoder_if vga ();

   logic [2*H-1:0] lineData;
   logic           lineValid;
   logic [8:0]     lineIdx;
   logic           frameDone;
   logic [8:0]     activeHeight;
   logic           timingErr;
   logic           colorErr;
   logic [15:0]    frameCrc;

   vga_stream_decoder #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .pixelCLK     (pixelCLK),
      .RST          (RST),
      .vga          (vga),
      .lineData     (lineData),
      .lineValid    (lineValid),
      .lineIdx      (lineIdx),
      .frameDone    (frameDone),
      .activeHeight (activeHeight),
      .timingErr    (timingErr),
      .colorErr     (colorErr),
      .frameCrc     (frameCrc)
   );

   int checks = 0;
   int failures = 0;

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Pulse monitor, sampled on the falling edge.
   int             lvCount = 0;
   int             fdCount = 0;
   logic [8:0]     lastIdx = '0;
   logic [8:0]     lastHeight = '0;
   logic [15:0]    lastCrc = '0;
   logic [2*H-1:0] lastData = '0;

   always @(negedge pixelCLK) begin
      if (lineValid) begin
         lvCount  = lvCount + 1;
         lastIdx  = lineIdx;
         lastData = lineData;
      end
      if (frameDone) begin
         fdCount    = fdCount + 1;
         lastHeight = activeHeight;
         lastCrc    = frameCrc;
      end
   end

   function automatic logic [23:0] rgbOf(input logic [1:0] code);
      case (code)
         2'd1:    return 24'hFF0000;
         2'd2:    return 24'h00FF00;
         2'd3:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [15:0] crcModel(input logic [15:0] c, input logic [1:0] code);
      logic [15:0] r;
      logic fb;
      r = c;
      for (int i = 1; i >= 0; i--) begin
         fb = r[15] ^ code[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   logic lvNow, fdNow;
   int   lvAt, fdAt;

   task automatic drive(input logic blank, input logic vs, input logic [23:0] rgb);
      @(posedge pixelCLK);
      #1;
      lvNow = lineValid;
      fdNow = frameDone;
      vga.VGA_BLANK_N = blank;
      vga.VGA_VS      = vs;
      vga.VGA_HS      = blank;
      {vga.VGA_R, vga.VGA_G, vga.VGA_B} = rgb;
   endtask

   // mode 0: pixel n = n%4, mode 1: all black; badPos gets (128,0,0).
   task automatic sendLine(input int nPix, input int mode, input int badPos, input int gap);
      logic [1:0] code;
      for (int n = 0; n < nPix; n++) begin
         code = (mode == 0) ? 2'(n % 4) : 2'd0;
         drive(1'b1, 1'b1, (n == badPos) ? 24'h800000 : rgbOf(code));
      end
      lvAt = -1;
      for (int g = 0; g < gap; g++) begin
         drive(1'b0, 1'b1, 24'h0);
         if (lvNow && lvAt < 0) lvAt = g;
      end
   endtask

   task automatic vsPulse();
      fdAt = -1;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, (k < 3) ? 1'b0 : 1'b1, 24'h0);
         if (fdNow && fdAt < 0) fdAt = k;
      end
   endtask

   initial begin
      #950us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [2*H-1:0] expLine;
   logic [15:0]    expCrcA, expCrcB;
   int             base, fdBase;

   initial begin
      for (int n = 0; n < H; n++) expLine[2*n +: 2] = 2'(n % 4);
      expCrcA = 16'hFFFF;
      expCrcB = 16'hFFFF;
      for (int l = 0; l < V; l++)
         for (int n = 0; n < H; n++) begin
            expCrcA = crcModel(expCrcA, 2'(n % 4));
            expCrcB = crcModel(expCrcB, 2'd0);
         end
`ifndef VGA_DEC_CRC_EN
      expCrcA = 16'h0;
      expCrcB = 16'h0;
`endif

      RST = 1'b1;
      vga.VGA_BLANK_N = 1'b0;
      vga.VGA_VS = 1'b1;
      vga.VGA_HS = 1'b1;
      vga.VGA_R = 8'h0;
      vga.VGA_G = 8'h0;
      vga.VGA_B = 8'h0;
      repeat (4) @(posedge pixelCLK);
      #1;
      checkVal("reset_lineValid", lineValid, 0);
      checkVal("reset_frameDone", frameDone, 0);
      checkVal("reset_lineIdx", lineIdx, 0);
      checkVal("reset_activeHeight", activeHeight, 0);
      checkVal("reset_errs", {timingErr, colorErr}, 0);
      checkVal("reset_frameCrc", frameCrc, 0);
      checkVal("reset_lineData_zero", lineData == '0, 1);
      RST = 1'b0;

      // First VS after reset opens a frame without a frameDone.
      vsPulse();
      checkVal("first_vs_no_frameDone", fdCount, 0);

      // Frame A: clean n%4 frame.
      for (int l = 0; l < V; l++) begin
         base = lvCount;
         sendLine(H, 0, -1, HBLANK);
         checkVal($sformatf("A_lv_line%0d", l), lvCount - base, 1);
         checkVal($sformatf("A_idx_line%0d", l), lastIdx, l);
         checkVal($sformatf("A_data_line%0d", l), lastData == expLine, 1);
         if (l == 0) begin
            checkVal("A_lv_latency", lvAt, 2);
            checkVal("A_pix0", lastData[1:0], 0);
            checkVal("A_pix1", lastData[3:2], 1);
            checkVal("A_pixLast", lastData[2*H-1 -: 2], 3);
         end
      end
      vsPulse();
      checkVal("A_frameDone_count", fdCount, 1);
      checkVal("A_frameDone_latency", fdAt, 2);
      checkVal("A_activeHeight", lastHeight, V);
      checkVal("A_frameCrc", lastCrc, expCrcA);
      checkVal("A_errs", {timingErr, colorErr}, 0);

      // Frame B: all-black frame.
      for (int l = 0; l < V; l++) sendLine(H, 1, -1, HBLANK);
      checkVal("B_lastData_black", lastData == '0, 1);
      vsPulse();
      checkVal("B_frameDone_count", fdCount, 2);
      checkVal("B_activeHeight", lastHeight, V);
      checkVal("B_frameCrc", lastCrc, expCrcB);
      checkVal("B_errs", {timingErr, colorErr}, 0);

      // Frame C: short line, illegal colour, VS abort mid line 10.
      base = lvCount;
      sendLine(H - 1, 0, -1, HBLANK);
      checkVal("C_short_lv", lvCount - base, 1);
      checkVal("C_short_timingErr", timingErr, 1);
      checkVal("C_short_colorErr", colorErr, 0);
      sendLine(H, 0, 5, HBLANK);
      checkVal("C_bad_lv", lvCount - base, 2);
      checkVal("C_bad_idx", lastIdx, 1);
      checkVal("C_bad_colorErr", colorErr, 1);
      checkVal("C_bad_code", lastData[11:10], 0);
      checkVal("C_bad_next", lastData[13:12], 2);
      for (int l = 2; l < 10; l++) sendLine(H, 0, -1, HBLANK);
      checkVal("C_lines_before_abort", lvCount - base, 10);
      sendLine(400, 0, -1, 0);
      vsPulse();
      checkVal("C_abort_no_lv", lvCount - base, 10);
      checkVal("C_frameDone_count", fdCount, 3);
      checkVal("C_activeHeight", lastHeight, 10);

      // Frame D: short frame, colour error must still be flagged.
      sendLine(H, 1, -1, HBLANK);
      sendLine(H, 1, -1, HBLANK);
      vsPulse();
      checkVal("D_activeHeight", lastHeight, 2);
      checkVal("D_colorErr_sticky", colorErr, 1);
      checkVal("D_timingErr_sticky", timingErr, 1);

      // Frame E: reset in the middle of line 5.
      for (int l = 0; l < 5; l++) sendLine(H, 0, -1, HBLANK);
      checkVal("E_idx_before_rst", lastIdx, 4);
      sendLine(300, 0, -1, 0);
      @(posedge pixelCLK);
      #1;
      RST = 1'b1;
      #2;
      checkVal("E_rst_lineValid", lineValid, 0);
      checkVal("E_rst_lineIdx", lineIdx, 0);
      checkVal("E_rst_activeHeight", activeHeight, 0);
      checkVal("E_rst_errs", {timingErr, colorErr}, 0);
      checkVal("E_rst_frameCrc", frameCrc, 0);
      checkVal("E_rst_lineData_zero", lineData == '0, 1);
      @(posedge pixelCLK);
      #1;
      RST = 1'b0;
      base   = lvCount;
      fdBase = fdCount;
      sendLine(H - 300, 0, -1, HBLANK);
      sendLine(H, 0, -1, HBLANK);
      checkVal("E_no_lv_without_vs", lvCount - base, 0);
      vsPulse();
      checkVal("E_no_frameDone_after_rst", fdCount - fdBase, 0);

      // Frame F: one line more than the frame holds.
      for (int l = 0; l < V; l++) sendLine(H, 0, -1, HBLANK);
      checkVal("F_lv_count", lvCount - base, V);
      checkVal("F_timingErr_before_extra", timingErr, 0);
      sendLine(H, 0, -1, HBLANK);
      checkVal("F_extra_no_lv", lvCount - base, V);
      checkVal("F_extra_idx", lastIdx, V - 1);
      checkVal("F_extra_timingErr", timingErr, 1);
      vsPulse();
      checkVal("F_frameDone", fdCount - fdBase, 1);
      checkVal("F_activeHeight", lastHeight, V);
      checkVal("F_colorErr", colorErr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
